// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the instruction-fetch sequencer: state codes, next-PC
// select codes and the default halt instruction word.
package fetch_ctrl_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BEQ = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;

    localparam logic [31:0] HALT_INST_DEFAULT = 32'h0000_000C;

    // Jump outranks a taken branch.
    function automatic logic [1:0] pc_select(input logic jump, input logic branch,
                                             input logic z);
        if (jump)
            return PCSEL_JMP;
        else if (branch && z)
            return PCSEL_BEQ;
        else
            return PCSEL_SEQ;
    endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Loadable up-counter with synchronous clear and enable; tc flags the
// final permitted wait cycle (count == MEM_TIMEOUT-1).
module fetch_timeout_cnt #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle instruction-fetch sequencer with memory timeout and halt detection.
// Define FETCH_CTRL_PERF_EN to build the InstCount/StallCycles counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [31:0] HALT_INST   = HALT_INST_DEFAULT
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Start,
    input  logic        IMemReady,
    input  logic [31:0] Inst,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Z,
    input  logic        ExecDone,
    input  logic        Stall,
    output logic        IMemReq,
    output logic        IRWrite,
    output logic        InstValid,
    output logic        PCWrite,
    output logic [1:0]  PCSel,
    output logic        Halted,
    output logic        Error,
    output logic [2:0]  State,
    output logic [31:0] InstCount,
    output logic [31:0] StallCycles
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [2:0] state_q, state_d;
    logic       to_clr, to_en, to_tc;

    fetch_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk      (Clk),
        .rst      (Clr),
        .clr      (to_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (to_en),
        .tc       (to_tc)
    );

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // The timeout counter is cleared on every transition into FETCH.
    always_comb begin
        state_d = state_q;
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        PCSel   = PCSEL_SEQ;
        to_clr  = 1'b0;
        to_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_FETCH;
                    to_clr  = 1'b1;
                end
            end
            S_FETCH: begin
                if (IMemReady) begin
                    IRWrite = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    to_en = 1'b1;
                    if (to_tc)
                        state_d = S_ERROR;
                end
            end
            S_ISSUE: begin
                if (Inst == HALT_INST) begin
                    state_d = S_HALT;
                end else if (ExecDone && !Stall) begin
                    PCWrite = 1'b1;
                    PCSel   = pc_select(Jump, Branch, Z);
                    state_d = S_FETCH;
                    to_clr  = 1'b1;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    assign IMemReq   = (state_q == S_FETCH);
    assign InstValid = (state_q == S_ISSUE);
    assign Halted    = (state_q == S_HALT);
    assign Error     = (state_q == S_ERROR);
    assign State     = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] inst_cnt_q, stall_cnt_q;

    // Both events are confined to ISSUE, so the counters freeze in HALT/ERROR.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            inst_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (PCWrite)
                inst_cnt_q <= inst_cnt_q + 32'd1;
            if ((state_q == S_ISSUE) && Stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign InstCount   = inst_cnt_q;
    assign StallCycles = stall_cnt_q;
`else
    assign InstCount   = '0;
    assign StallCycles = '0;
`endif

endmodule
